// File: rtl/powlib_fifoctrl_if.sv
// Handshake and RAM-control bundle between the FIFO controller and its
// producer, consumer and external dual-port RAM.
interface powlib_fifoctrl_if #(
  parameter int WIDX = 3,
  parameter int WCNT = 4
);
  logic            in_vld;
  logic            in_rdy;
  logic            out_vld;
  logic            out_rdy;
  logic [WIDX-1:0] wridx;
  logic            wrvld;
  logic [WIDX-1:0] rdidx;
  logic [WCNT-1:0] cnt;
  logic            full;
  logic            empty;
  logic            afull;

  // Controller side.
  modport slave (
    input  in_vld, out_rdy,
    output in_rdy, out_vld, wridx, wrvld, rdidx, cnt, full, empty, afull
  );

  // Producer / consumer / RAM side.
  modport master (
    output in_vld, out_rdy,
    input  in_rdy, out_vld, wridx, wrvld, rdidx, cnt, full, empty, afull
  );
endinterface

// File: rtl/powlib_fifoctrl.sv
// FIFO pointer/occupancy controller for an external asynchronous-read
// dual-port RAM. Holds no data itself: it only steers the RAM write strobe,
// the write and read indices, and the handshake/status flags.
package powlib_fifoctrl_pkg;

  // Ceiling log2, never less than one bit.
  function automatic int powlib_clogb2(input int value);
    int result;
    result = 32'sd0;
    for (int v = value - 32'sd1; v > 32'sd0; v = v >> 1) begin
      result = result + 32'sd1;
    end
    if (result == 32'sd0) begin
      result = 32'sd1;
    end
    return result;
  endfunction

endpackage

module powlib_fifoctrl
  import powlib_fifoctrl_pkg::*;
#(
  parameter int D    = 32'sd8,
  parameter int WIDX = powlib_clogb2(D),
  parameter int WCNT = powlib_clogb2(D + 32'sd1),
  parameter int AFT  = D - 32'sd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  powlib_fifoctrl_if.slave bus
);

  localparam logic [WIDX-1:0] PTR_LAST = WIDX'(D - 32'sd1);
  localparam logic [WIDX-1:0] PTR_ONE  = WIDX'(32'sd1);
  localparam logic [WIDX-1:0] PTR_ZERO = WIDX'(32'sd0);
  localparam logic [WCNT-1:0] CNT_FULL = WCNT'(D);
  localparam logic [WCNT-1:0] CNT_AFT  = WCNT'(AFT);
  localparam logic [WCNT-1:0] CNT_ONE  = WCNT'(32'sd1);
  localparam logic [WCNT-1:0] CNT_ZERO = WCNT'(32'sd0);

  // Pointer advance with wrap from D-1 back to 0 (D need not be a power of two).
  function automatic logic [WIDX-1:0] ptr_inc(input logic [WIDX-1:0] p);
    if (p == PTR_LAST) begin
      return PTR_ZERO;
    end else begin
      return p + PTR_ONE;
    end
  endfunction

  logic [WIDX-1:0] wrptr_r;
  logic [WIDX-1:0] rdptr_r;
  logic [WCNT-1:0] cnt_r;
  logic [WIDX-1:0] wrptr_nxt_s;
  logic [WIDX-1:0] rdptr_nxt_s;
  logic [WCNT-1:0] cnt_nxt_s;
  logic            in_rdy_s;
  logic            out_vld_s;
  logic            push_s;
  logic            pop_s;

  // Handshakes are gated by reset and flush so nothing is accepted or
  // offered while the controller is being cleared. No full-bypass: a full
  // FIFO refuses a push even when a pop happens in the same cycle.
  assign in_rdy_s  = rst & ~clr & (cnt_r != CNT_FULL);
  assign out_vld_s = rst & ~clr & (cnt_r != CNT_ZERO);
  assign push_s    = bus.in_vld & in_rdy_s;
  assign pop_s     = out_vld_s & bus.out_rdy;

  assign bus.in_rdy  = in_rdy_s;
  assign bus.out_vld = out_vld_s;
  assign bus.wrvld   = push_s;
  assign bus.wridx   = wrptr_r;
  assign bus.rdidx   = rdptr_r;
  assign bus.cnt     = cnt_r;
  assign bus.full    = (cnt_r == CNT_FULL);
  assign bus.empty   = (cnt_r == CNT_ZERO);
  assign bus.afull   = (cnt_r >= CNT_AFT);

  // Next pointers and occupancy; flush overrides any push/pop.
  always_comb begin
    wrptr_nxt_s = wrptr_r;
    rdptr_nxt_s = rdptr_r;
    cnt_nxt_s   = cnt_r;
    if (clr) begin
      wrptr_nxt_s = PTR_ZERO;
      rdptr_nxt_s = PTR_ZERO;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      if (push_s) begin
        wrptr_nxt_s = ptr_inc(wrptr_r);
      end else begin
        wrptr_nxt_s = wrptr_r;
      end
      if (pop_s) begin
        rdptr_nxt_s = ptr_inc(rdptr_r);
      end else begin
        rdptr_nxt_s = rdptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
        2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
        default: cnt_nxt_s = cnt_r;
      endcase
    end
  end

  // Pointer and occupancy registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrptr_r <= PTR_ZERO;
      rdptr_r <= PTR_ZERO;
      cnt_r   <= CNT_ZERO;
    end else begin
      wrptr_r <= wrptr_nxt_s;
      rdptr_r <= rdptr_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_powlib_fifoctrl.sv
// Directed self-checking bench for powlib_fifoctrl with D=4, AFT=3.
// A small RAM model plus scoreboard checks that entries leave in order.
module tb_powlib_fifoctrl;
  localparam int D = 4;
  localparam int AFT = 3;
  localparam int WIDX = 2;
  localparam int WCNT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [0:D-1];
  logic [7:0] wdata = 8'h10;
  logic [7:0] exp_q [$];
  logic [7:0] exp_d;

  powlib_fifoctrl_if #(.WIDX(WIDX), .WCNT(WCNT)) bus ();

  powlib_fifoctrl #(.D(D), .WIDX(WIDX), .WCNT(WCNT), .AFT(AFT)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // RAM model: write on strobe, check head data on every pop.
  always @(posedge clk) begin
    if (!rst || clr) begin
      exp_q.delete();
    end else begin
      if (bus.out_vld && bus.out_rdy) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL ram_order: pop at rdidx %0d with nothing expected", bus.rdidx);
        end else begin
          exp_d = exp_q.pop_front();
          if (mem[bus.rdidx] !== exp_d) begin
            n_err++;
            $display("FAIL ram_order: got %0h want %0h", mem[bus.rdidx], exp_d);
          end
        end
      end
      if (bus.wrvld) begin
        mem[bus.wridx] <= wdata;
        exp_q.push_back(wdata);
        wdata <= wdata + 8'd1;
      end
    end
  end

  // Reset discards all expected contents immediately.
  always @(negedge rst) exp_q.delete();

  task automatic test_reset();
    bus.in_vld = 1'b1;
    bus.out_rdy = 1'b1;
    #3;
    n_cmp++; if (bus.in_rdy !== 1'b0) begin n_err++; $display("FAIL rst_in_rdy: got %b want 0", bus.in_rdy); end
    n_cmp++; if (bus.out_vld !== 1'b0) begin n_err++; $display("FAIL rst_out_vld: got %b want 0", bus.out_vld); end
    n_cmp++; if (bus.wrvld !== 1'b0) begin n_err++; $display("FAIL rst_wrvld: got %b want 0", bus.wrvld); end
    n_cmp++; if (bus.wridx !== 2'd0) begin n_err++; $display("FAIL rst_wridx: got %0d want 0", bus.wridx); end
    n_cmp++; if (bus.rdidx !== 2'd0) begin n_err++; $display("FAIL rst_rdidx: got %0d want 0", bus.rdidx); end
    n_cmp++; if (bus.cnt !== 3'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", bus.cnt); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b want 1", bus.empty); end
    n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b want 0", bus.full); end
    n_cmp++; if (bus.afull !== 1'b0) begin n_err++; $display("FAIL rst_afull: got %b want 0", bus.afull); end
    @(posedge clk); #1;
    n_cmp++; if (bus.cnt !== 3'd0) begin n_err++; $display("FAIL rst_hold_cnt: got %0d want 0", bus.cnt); end
    bus.in_vld = 1'b0;
    bus.out_rdy = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.in_rdy !== 1'b1) begin n_err++; $display("FAIL rel_in_rdy: got %b want 1", bus.in_rdy); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL rel_empty: got %b want 1", bus.empty); end
    @(posedge clk); #1;
    n_cmp++; if (bus.cnt !== 3'd0) begin n_err++; $display("FAIL rel_cnt: got %0d want 0", bus.cnt); end
  endtask

  task automatic test_fill();
    bus.out_rdy = 1'b0;
    for (int i = 0; i < D; i++) begin
      bus.in_vld = 1'b1;
      #1;
      n_cmp++; if (bus.wrvld !== 1'b1) begin n_err++; $display("FAIL fill_wrvld[%0d]: got %b want 1", i, bus.wrvld); end
      n_cmp++; if (bus.wridx !== WIDX'(i)) begin n_err++; $display("FAIL fill_wridx[%0d]: got %0d want %0d", i, bus.wridx, i); end
      @(posedge clk); #1;
      n_cmp++; if (bus.cnt !== WCNT'(i + 1)) begin n_err++; $display("FAIL fill_cnt[%0d]: got %0d want %0d", i, bus.cnt, i + 1); end
      n_cmp++; if (bus.afull !== (i + 1 >= AFT)) begin n_err++; $display("FAIL fill_afull[%0d]: got %b want %b", i, bus.afull, (i + 1 >= AFT)); end
      n_cmp++; if (bus.full !== (i + 1 == D)) begin n_err++; $display("FAIL fill_full[%0d]: got %b want %b", i, bus.full, (i + 1 == D)); end
    end
    n_cmp++; if (bus.in_rdy !== 1'b0) begin n_err++; $display("FAIL fill_in_rdy: got %b want 0", bus.in_rdy); end
    n_cmp++; if (bus.wrvld !== 1'b0) begin n_err++; $display("FAIL fill_5th_wrvld: got %b want 0", bus.wrvld); end
    @(posedge clk); #1;
    n_cmp++; if (bus.cnt !== 3'd4) begin n_err++; $display("FAIL fill_5th_cnt: got %0d want 4", bus.cnt); end
    n_cmp++; if (bus.wridx !== 2'd0) begin n_err++; $display("FAIL fill_wrap: got %0d want 0", bus.wridx); end
    bus.in_vld = 1'b0;
  endtask

  task automatic test_drain();
    bus.out_rdy = 1'b1;
    for (int i = 0; i < D; i++) begin
      #1;
      n_cmp++; if (bus.out_vld !== 1'b1) begin n_err++; $display("FAIL drain_out_vld[%0d]: got %b want 1", i, bus.out_vld); end
      n_cmp++; if (bus.rdidx !== WIDX'(i)) begin n_err++; $display("FAIL drain_rdidx[%0d]: got %0d want %0d", i, bus.rdidx, i); end
      @(posedge clk); #1;
      n_cmp++; if (bus.cnt !== WCNT'(D - 1 - i)) begin n_err++; $display("FAIL drain_cnt[%0d]: got %0d want %0d", i, bus.cnt, D - 1 - i); end
    end
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", bus.empty); end
    n_cmp++; if (bus.out_vld !== 1'b0) begin n_err++; $display("FAIL drain_out_vld_end: got %b want 0", bus.out_vld); end
    n_cmp++; if (bus.rdidx !== 2'd0) begin n_err++; $display("FAIL drain_wrap: got %0d want 0", bus.rdidx); end
    bus.out_rdy = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.in_vld = 1'b1;
    bus.out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.cnt !== 3'd2) begin n_err++; $display("FAIL b2b_start_cnt: got %0d want 2", bus.cnt); end
    bus.out_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      n_cmp++; if (bus.wridx !== WIDX'((2 + k) % D)) begin n_err++; $display("FAIL b2b_wridx[%0d]: got %0d want %0d", k, bus.wridx, (2 + k) % D); end
      n_cmp++; if (bus.rdidx !== WIDX'(k % D)) begin n_err++; $display("FAIL b2b_rdidx[%0d]: got %0d want %0d", k, bus.rdidx, k % D); end
      n_cmp++; if (bus.wrvld !== 1'b1) begin n_err++; $display("FAIL b2b_wrvld[%0d]: got %b want 1", k, bus.wrvld); end
      @(posedge clk); #1;
      n_cmp++; if (bus.cnt !== 3'd2) begin n_err++; $display("FAIL b2b_cnt[%0d]: got %0d want 2", k, bus.cnt); end
    end
    bus.in_vld = 1'b0;
    bus.out_rdy = 1'b0;
  endtask

  task automatic test_full_pushpop();
    bus.in_vld = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL fpp_full: got %b want 1", bus.full); end
    bus.out_rdy = 1'b1;
    #1;
    n_cmp++; if (bus.wrvld !== 1'b0) begin n_err++; $display("FAIL fpp_wrvld: got %b want 0", bus.wrvld); end
    n_cmp++; if (bus.out_vld !== 1'b1) begin n_err++; $display("FAIL fpp_out_vld: got %b want 1", bus.out_vld); end
    @(posedge clk); #1;
    n_cmp++; if (bus.cnt !== 3'd3) begin n_err++; $display("FAIL fpp_pop_cnt: got %0d want 3", bus.cnt); end
    bus.out_rdy = 1'b0;
    #1;
    n_cmp++; if (bus.wrvld !== 1'b1) begin n_err++; $display("FAIL fpp_push_wrvld: got %b want 1", bus.wrvld); end
    @(posedge clk); #1;
    n_cmp++; if (bus.cnt !== 3'd4) begin n_err++; $display("FAIL fpp_push_cnt: got %0d want 4", bus.cnt); end
    bus.in_vld = 1'b0;
  endtask

  task automatic test_clr();
    bus.out_rdy = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.cnt !== 3'd3) begin n_err++; $display("FAIL clr_pre_cnt: got %0d want 3", bus.cnt); end
    clr = 1'b1;
    bus.in_vld = 1'b1;
    #1;
    n_cmp++; if (bus.wrvld !== 1'b0) begin n_err++; $display("FAIL clr_wrvld: got %b want 0", bus.wrvld); end
    n_cmp++; if (bus.in_rdy !== 1'b0) begin n_err++; $display("FAIL clr_in_rdy: got %b want 0", bus.in_rdy); end
    n_cmp++; if (bus.out_vld !== 1'b0) begin n_err++; $display("FAIL clr_out_vld: got %b want 0", bus.out_vld); end
    @(posedge clk); #1;
    clr = 1'b0;
    bus.in_vld = 1'b0;
    bus.out_rdy = 1'b0;
    n_cmp++; if (bus.cnt !== 3'd0) begin n_err++; $display("FAIL clr_cnt: got %0d want 0", bus.cnt); end
    n_cmp++; if (bus.wridx !== 2'd0) begin n_err++; $display("FAIL clr_wridx: got %0d want 0", bus.wridx); end
    n_cmp++; if (bus.rdidx !== 2'd0) begin n_err++; $display("FAIL clr_rdidx: got %0d want 0", bus.rdidx); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL clr_empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_async_rst();
    bus.in_vld = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.in_vld = 1'b0;
    n_cmp++; if (bus.cnt !== 3'd2) begin n_err++; $display("FAIL arst_pre_cnt: got %0d want 2", bus.cnt); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (bus.cnt !== 3'd0) begin n_err++; $display("FAIL arst_cnt: got %0d want 0", bus.cnt); end
    n_cmp++; if (bus.wridx !== 2'd0) begin n_err++; $display("FAIL arst_wridx: got %0d want 0", bus.wridx); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL arst_empty: got %b want 1", bus.empty); end
    n_cmp++; if (bus.out_vld !== 1'b0) begin n_err++; $display("FAIL arst_out_vld: got %b want 0", bus.out_vld); end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.cnt !== 3'd0) begin n_err++; $display("FAIL arst_rel_cnt: got %0d want 0", bus.cnt); end
    bus.in_vld = 1'b1;
    #1;
    n_cmp++; if (bus.wridx !== 2'd0) begin n_err++; $display("FAIL arst_push_wridx: got %0d want 0", bus.wridx); end
    n_cmp++; if (bus.wrvld !== 1'b1) begin n_err++; $display("FAIL arst_push_wrvld: got %b want 1", bus.wrvld); end
    @(posedge clk); #1;
    bus.in_vld = 1'b0;
    n_cmp++; if (bus.out_vld !== 1'b1) begin n_err++; $display("FAIL arst_out_vld_next: got %b want 1", bus.out_vld); end
    n_cmp++; if (bus.rdidx !== 2'd0) begin n_err++; $display("FAIL arst_rdidx: got %0d want 0", bus.rdidx); end
    bus.out_rdy = 1'b1;
    @(posedge clk); #1;
    bus.out_rdy = 1'b0;
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL arst_final_empty: got %b want 1", bus.empty); end
  endtask

  initial begin
    bus.in_vld = 1'b0;
    bus.out_rdy = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_full_pushpop();
    test_clr();
    test_async_rst();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
